// File: rtl/lvds_input_read.sv
// AXI4-Lite read responder for lvds_input: serves CR/DSIZE from the write block,
// plus clear-on-read sticky status (SR) and a saturating sample counter (SCNT).
module lvds_input_read (
  input  logic        i_aclk,
  input  logic        i_areset,
  input  logic [31:0] i_araddr,
  input  logic        i_arvalid,
  output logic        o_arready,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp,
  output logic        o_rvalid,
  input  logic        i_rready,
  input  logic [31:0] i_dsize,
  input  logic        i_cr_test,
  input  logic        i_cr_rt,
  input  logic        i_cr_start,
  input  logic        i_busy,
  input  logic        i_done_p,
  input  logic        i_ovf_p,
  input  logic        i_sample_valid
);

  localparam logic [7:0] AXI_ADDR_CR    = 8'h00;
  localparam logic [7:0] AXI_ADDR_DSIZE = 8'h04;
  localparam logic [7:0] AXI_ADDR_SR    = 8'h08;
  localparam logic [7:0] AXI_ADDR_SCNT  = 8'h0C;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [1:0] RESP_SLVERR    = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_rdata, w_rdata;
  logic [1:0]  r_rresp, w_rresp;
  logic        r_done, r_ovf;
  logic [31:0] r_scnt;
  logic        w_arready, w_rvalid, w_sr_rd;
  logic        w_unused;

  // only the low byte of the address is decoded
  assign w_unused = ^i_araddr[31:8];

  always_comb begin
    w_state_nxt = r_state;
    w_arready   = 1'b0;
    w_rvalid    = 1'b0;
    case (r_state)
      S_IDLE: if (i_arvalid) w_state_nxt = S_ADDR;
      S_ADDR: begin
        w_arready   = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_rvalid = 1'b1;
        if (i_rready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = 32'd0;
    w_rresp = RESP_OKAY;
    case (i_araddr[7:0])
      AXI_ADDR_CR:    w_rdata = {29'd0, i_cr_rt, i_cr_test, 1'b0};
      AXI_ADDR_DSIZE: w_rdata = i_dsize;
      AXI_ADDR_SR:    w_rdata = {29'd0, r_ovf, r_done, i_busy};
      AXI_ADDR_SCNT:  w_rdata = r_scnt;
      default:        w_rresp = RESP_SLVERR;
    endcase
  end

  assign w_sr_rd = (r_state == S_ADDR) && (i_araddr[7:0] == AXI_ADDR_SR);

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_state <= S_IDLE;
      r_rdata <= 32'd0;
      r_rresp <= RESP_OKAY;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_ADDR) begin
        r_rdata <= w_rdata;
        r_rresp <= w_rresp;
      end
    end
  end

  // a set pulse coinciding with the SR clear wins, so no event is lost
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= i_done_p | (r_done & ~w_sr_rd);
      r_ovf  <= i_ovf_p  | (r_ovf  & ~w_sr_rd);
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset)
      r_scnt <= 32'd0;
    else if (i_cr_start)
      r_scnt <= 32'd0;
    else if (i_sample_valid && (r_scnt != 32'hFFFF_FFFF))
      r_scnt <= r_scnt + 32'd1;
  end

  assign o_arready = w_arready;
  assign o_rvalid  = w_rvalid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;

endmodule

// File: tb/tb_lvds_input_read.sv
// Directed bench for lvds_input_read: a register-level model predicts every read,
// a negedge compare process checks the handshake and data each cycle.
module tb_lvds_input_read;

  logic        clk = 1'b0;
  logic        i_areset = 1'b1;
  logic [31:0] i_araddr = '0;
  logic        i_arvalid = 1'b0;
  logic        o_arready;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp;
  logic        o_rvalid;
  logic        i_rready = 1'b0;
  logic [31:0] i_dsize = '0;
  logic        i_cr_test = 1'b0, i_cr_rt = 1'b0, i_cr_start = 1'b0, i_busy = 1'b0;
  logic        i_done_p = 1'b0, i_ovf_p = 1'b0, i_sample_valid = 1'b0;

  lvds_input_read dut (
    .i_aclk(clk), .i_areset(i_areset), .i_araddr(i_araddr), .i_arvalid(i_arvalid),
    .o_arready(o_arready), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid),
    .i_rready(i_rready), .i_dsize(i_dsize), .i_cr_test(i_cr_test), .i_cr_rt(i_cr_rt),
    .i_cr_start(i_cr_start), .i_busy(i_busy), .i_done_p(i_done_p), .i_ovf_p(i_ovf_p),
    .i_sample_valid(i_sample_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // register-level model
  bit          m_done = 0, m_ovf = 0, m_sr_clr = 0;
  logic [31:0] m_cnt = '0;

  // per-cycle expectations
  bit          chk_en = 0;
  logic        exp_arready = 0, exp_rvalid = 0;
  logic [31:0] exp_rdata = '0;
  logic [1:0]  exp_rresp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (i_areset) begin
      m_done = 0; m_ovf = 0; m_cnt = '0;
    end else begin
      if (m_sr_clr) begin m_done = 0; m_ovf = 0; end
      if (i_done_p) m_done = 1;
      if (i_ovf_p)  m_ovf  = 1;
      if (i_cr_start)                                   m_cnt = '0;
      else if (i_sample_valid && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("arready", {31'd0, o_arready}, {31'd0, exp_arready});
      chk("rvalid",  {31'd0, o_rvalid},  {31'd0, exp_rvalid});
      if (exp_rvalid) begin
        chk("rdata", o_rdata, exp_rdata);
        chk("rresp", {30'd0, o_rresp}, {30'd0, exp_rresp});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
    i_done_p = 0; i_ovf_p = 0; i_sample_valid = 0; i_cr_start = 0; m_sr_clr = 0;
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin i_sample_valid = 1; tick(); end
  endtask

  // issue one read; stall = cycles RREADY held low in the response phase
  task automatic do_read(input logic [31:0] addr, input int stall, input bit done_in_s1,
                         output logic [31:0] data, output logic [1:0] resp);
    i_arvalid = 1; i_araddr = addr;
    exp_arready = 0; exp_rvalid = 0;
    tick();
    exp_arready = 1;
    exp_rresp = 2'b00;
    case (addr[7:0])
      8'h00: exp_rdata = {29'd0, i_cr_rt, i_cr_test, 1'b0};
      8'h04: exp_rdata = i_dsize;
      8'h08: begin exp_rdata = {29'd0, m_ovf, m_done, i_busy}; m_sr_clr = 1; end
      8'h0C: exp_rdata = m_cnt;
      default: begin exp_rdata = '0; exp_rresp = 2'b10; end
    endcase
    i_done_p = done_in_s1;
    tick();
    i_arvalid = 0;
    exp_arready = 0; exp_rvalid = 1;
    for (int k = 0; k < stall; k++) begin
      i_rready = 0;
      i_arvalid = k[0];
      tick();
    end
    i_arvalid = 0;
    i_rready = 1;
    data = o_rdata; resp = o_rresp;
    tick();
    i_rready = 0;
    exp_rvalid = 0;
  endtask

  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    i_areset = 1;
    repeat (3) tick();
    i_areset = 0;
    chk("rst_arready", {31'd0, o_arready}, 32'd0);
    chk("rst_rvalid",  {31'd0, o_rvalid},  32'd0);
    chk("rst_rdata",   o_rdata, 32'd0);
    chk("rst_rresp",   {30'd0, o_rresp}, 32'd0);
    chk_en = 1;
    tick();

    i_dsize = 32'h0000_1234;
    do_read(32'h04, 0, 0, d, r);
    chk("dsize", d, 32'h0000_1234); chk("dsize_resp", {30'd0, r}, 32'd0);

    i_cr_test = 1; i_cr_rt = 1;
    do_read(32'h00, 0, 0, d, r);
    chk("cr", d, 32'h6);
    do_read(32'h3C, 0, 0, d, r);
    chk("bad_data", d, 32'h0); chk("bad_resp", {30'd0, r}, 32'h2);

    i_done_p = 1; tick(); tick();
    do_read(32'h08, 0, 0, d, r);
    chk("sr_done1", d, 32'h2);
    do_read(32'h08, 0, 0, d, r);
    chk("sr_clear", d, 32'h0);
    do_read(32'h08, 0, 1, d, r);
    chk("sr_race1", d, 32'h0);
    do_read(32'h08, 0, 0, d, r);
    chk("sr_race2", d, 32'h2);

    i_busy = 1; i_ovf_p = 1; i_cr_start = 1; tick();
    do_read(32'h08, 0, 0, d, r);
    chk("sr_ovf_busy", d, 32'h5);
    i_busy = 0;
    do_read(32'h08, 0, 0, d, r);
    chk("sr_ovf_clr", d, 32'h0);

    i_cr_start = 1; tick();
    pulses(5);
    do_read(32'h0C, 0, 0, d, r);
    chk("scnt5", d, 32'd5);
    do_read(32'h0C, 0, 0, d, r);
    chk("scnt_keep", d, 32'd5);

    force dut.r_scnt = 32'hFFFF_FFFE;
    #1 release dut.r_scnt;
    m_cnt = 32'hFFFF_FFFE;
    pulses(3);
    do_read(32'h0C, 0, 0, d, r);
    chk("scnt_sat", d, 32'hFFFF_FFFF);

    i_cr_start = 1; i_sample_valid = 1; tick();
    do_read(32'h0C, 0, 0, d, r);
    chk("scnt_start_race", d, 32'd0);

    pulses(2);
    do_read(32'h04, 10, 0, d, r);
    chk("stall_data", d, 32'h0000_1234);

    // reset while a response is pending
    i_ovf_p = 1; pulses(3);
    i_arvalid = 1; i_araddr = 32'h0C;
    exp_arready = 0; exp_rvalid = 0;
    tick();
    i_arvalid = 0;
    exp_arready = 1; exp_rdata = m_cnt; exp_rresp = 2'b00;
    tick();
    exp_arready = 0; exp_rvalid = 1;
    tick();
    i_areset = 1;
    tick();
    exp_rvalid = 0;
    i_areset = 0;
    chk("mid_rst_rdata", o_rdata, 32'd0);
    tick();
    do_read(32'h08, 0, 0, d, r);
    chk("post_rst_sr", d, 32'h0);
    do_read(32'h0C, 0, 0, d, r);
    chk("post_rst_scnt", d, 32'h0);
    chk("post_rst_resp", {30'd0, r}, 32'h0);

    tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lvds_input_read.md
# lvds_input_read

AXI4-Lite read-channel responder for the lvds_input IP, companion to the existing write-channel block on the same register slave. It serves reads from the control/config registers held by the write block and adds status and sample-count registers fed from the capture datapath. It owns clear-on-read sticky status flags and a saturating sample counter.

## Interface
- Parameters: none. Register offsets are `lvds_input_common` constants: AXI_ADDR_CR = 0x00, AXI_ADDR_DSIZE = 0x04, AXI_ADDR_SR = 0x08 (new), AXI_ADDR_SCNT = 0x0C (new). Decode uses ARADDR[7:0].
- ACLK  in  1  single clock for the whole block.
- ARESET  in  1  reset, synchronous, active-high.
- ARADDR  in  32  read address.
- ARVALID  in  1  read-address valid.
- ARREADY  out  1  read-address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read-data valid.
- RREADY  in  1  read-data ready.
- dsize  in  32  DSIZE value from the write block.
- cr_test, cr_rt  in  1 each  CR levels from the write block.
- cr_start  in  1  one-cycle start pulse from the write block.
- busy  in  1  capture in progress (live level).
- done_p  in  1  one-cycle capture-complete pulse.
- ovf_p  in  1  one-cycle FIFO-overflow pulse.
- sample_valid  in  1  one pulse per captured sample.

## Operation
- FSM states: S0 idle, S1 address accept, S2 response.
  - S0 -> S1 when ARVALID = 1.
  - S1 -> S2 unconditionally.
  - S2 -> S0 when RREADY = 1. Otherwise stay in S2.
- S1: ARREADY = 1. ARADDR[7:0] is decoded. RDATA and RRESP are registered at the end of S1 and held stable through S2.
- Read map:
  - CR: {29'b0, cr_rt, cr_test, 1'b0}. The start bit always reads 0.
  - DSIZE: dsize.
  - SR: {29'b0, ovf, done, busy}.
  - SCNT: sample counter.
  - Any other offset: RDATA = 0, RRESP = 2'b10 (SLVERR).
  - Mapped offsets return RRESP = 2'b00.
- Sticky flags `done` and `ovf`:
  - Set by done_p / ovf_p respectively.
  - Cleared in the S1 cycle of a read of SR; the snapshot holds the pre-clear value.
  - If a set pulse and the clear land in the same cycle, set wins: the flag stays 1 and is reported on the next read.
  - cr_start clears neither flag.
- Sample counter (32 bits):
  - Cleared to 0 by cr_start. Otherwise +1 per sample_valid.
  - Saturates at 0xFFFFFFFF; no wrap.
  - If cr_start and sample_valid coincide, the counter goes to 0; the concurrent sample is not counted.
  - Reading SCNT does not clear it.
- One outstanding read at a time. ARVALID is ignored outside S0.

## Timing
- Reset values: state S0; ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 2'b00; done = 0; ovf = 0; counter = 0.
- ARESET asserted mid-transaction: the next edge forces all reset values. Any pending response is dropped, and RVALID is 0 from that edge.
- Latency: ARVALID seen in S0 at edge n gives ARREADY = 1 in cycle n+1. RVALID = 1 from edge n+2.
- Minimum cost is 3 cycles per read when RREADY is held high. Back-to-back reads start one cycle after the RVALID/RREADY handshake.
- RVALID, once high, stays high with RDATA/RRESP unchanged until RREADY = 1.
- Snapshot time:
  - SR and SCNT values are those registered in S1; later changes are not reflected in the pending response.
  - busy is sampled live in S1.
- AWREADY/WREADY behaviour of the write block is unaffected; both blocks may be active in the same cycle.

## Test plan
- Reset, then read 0x04 after a write of DSIZE = 0x0000_1234 -> RDATA = 0x0000_1234, RRESP = 00. ARREADY pulses exactly 1 cycle; RVALID rises 2 cycles after ARVALID.
- cr_test = 1, cr_rt = 1; read 0x00 -> RDATA = 0x0000_0006. Read 0x3C -> RDATA = 0, RRESP = 10.
- done_p pulse, then read SR -> RDATA bit1 = 1. Second read -> bit1 = 0. Repeat with done_p in the S1 cycle of the first SR read -> first read returns bit1 per the pre-clear value, second read returns bit1 = 1.
- cr_start, then 5 sample_valid pulses; read 0x0C -> 5. Force counter to 0xFFFF_FFFE, apply 3 pulses -> 0xFFFF_FFFF. cr_start coinciding with sample_valid -> 0.
- Hold RREADY = 0 for 10 cycles in S2 -> RVALID and RDATA stable throughout. ARVALID toggling meanwhile -> no ARREADY.
- Assert ARESET while in S2 -> RVALID = 0 at the next edge, flags and counter = 0. A read issued afterwards completes normally.
